// File: rtl/color_centroid_tracker.sv
// color_centroid_tracker: per-frame RGB window match accumulator with sequential centroid divider
module color_centroid_tracker #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        run,
  input  logic        FVAL,
  input  logic        DVAL,
  input  logic [10:0] X,
  input  logic [10:0] Y,
  input  logic [9:0]  Rin,
  input  logic [9:0]  Gin,
  input  logic [9:0]  Bin,
  input  logic [9:0]  red_lo,
  input  logic [9:0]  red_hi,
  input  logic [9:0]  green_lo,
  input  logic [9:0]  green_hi,
  input  logic [9:0]  blue_lo,
  input  logic [9:0]  blue_hi,
  input  logic [19:0] min_count,
  output logic [9:0]  posX,
  output logic [9:0]  posY,
  output logic [9:0]  box_x0,
  output logic [9:0]  box_x1,
  output logic [9:0]  box_y0,
  output logic [9:0]  box_y1,
  output logic [19:0] count,
  output logic        found,
  output logic        done,
  output logic        busy,
  output logic        overrun
);
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
  state_t state, nxt;
  logic hit, m1, fval_q, eof1, eof2, rise, snap, step, fin, ok, gx, gy;
  logic [9:0] x1, y1;
  logic [9:0] min_x, min_y, max_x, max_y;
  logic [9:0] b_mnx, b_mny, b_mxx, b_mxy;
  logic [9:0] s_mnx, s_mny, s_mxx, s_mxy;
  logic [19:0] cnt, b_cnt, s_cnt, rx, ry;
  logic [29:0] sum_x, sum_y, b_sx, b_sy, qx, qy;
  logic [20:0] tx, ty;
  logic [4:0] iter;
  assign hit = DVAL && run && X < H_LIM && Y < V_LIM &&
               Rin >= red_lo && Rin <= red_hi &&
               Gin >= green_lo && Gin <= green_hi &&
               Bin >= blue_lo && Bin <= blue_hi;
  assign rise = FVAL && !fval_q;
  assign tx = {rx, qx[29]};
  assign ty = {ry, qy[29]};
  assign gx = tx >= {1'b0, s_cnt};
  assign gy = ty >= {1'b0, s_cnt};
  assign ok = s_cnt != '0 && s_cnt >= min_count;
  // classify pixel, capture coordinates, and build the delayed end-of-frame strobe
  always_ff @(posedge CLK) begin
    if (Reset) begin
      m1     <= 1'b0;
      x1     <= '0;
      y1     <= '0;
      fval_q <= 1'b0;
      eof1   <= 1'b0;
      eof2   <= 1'b0;
    end else begin
      m1     <= hit;
      x1     <= X[9:0];
      y1     <= Y[9:0];
      fval_q <= FVAL;
      eof1   <= !FVAL && fval_q;
      eof2   <= eof1;
    end
  end
  // accumulator base: init values on frame start so a match on that edge counts first
  always_comb begin
    b_cnt = rise ? '0 : cnt;
    b_sx  = rise ? '0 : sum_x;
    b_sy  = rise ? '0 : sum_y;
    b_mnx = rise ? 10'd1023 : min_x;
    b_mny = rise ? 10'd1023 : min_y;
    b_mxx = rise ? 10'd0 : max_x;
    b_mxy = rise ? 10'd0 : max_y;
  end
  // frame accumulators for count, coordinate sums and bounding box
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt   <= '0;
      sum_x <= '0;
      sum_y <= '0;
      min_x <= 10'd1023;
      min_y <= 10'd1023;
      max_x <= '0;
      max_y <= '0;
    end else begin
      cnt   <= m1 ? b_cnt + 20'd1 : b_cnt;
      sum_x <= m1 ? b_sx + 30'(x1) : b_sx;
      sum_y <= m1 ? b_sy + 30'(y1) : b_sy;
      min_x <= (m1 && x1 < b_mnx) ? x1 : b_mnx;
      min_y <= (m1 && y1 < b_mny) ? y1 : b_mny;
      max_x <= (m1 && x1 > b_mxx) ? x1 : b_mxx;
      max_y <= (m1 && y1 > b_mxy) ? y1 : b_mxy;
    end
  end
  // state register
  always_ff @(posedge CLK) begin
    if (Reset) state <= S_IDLE;
    else state <= nxt;
  end
  // next state: wait for EOF, run 30 divide steps, spend one cycle publishing
  always_comb begin
    nxt = state == S_IDLE ? (eof2 ? S_DIV : S_IDLE) :
          state == S_DIV  ? (iter == 5'd29 ? S_DONE : S_DIV) : S_IDLE;
  end
  // state decode
  always_comb begin
    busy = state != S_IDLE;
    snap = state == S_IDLE && eof2;
    step = state == S_DIV;
    fin  = state == S_DONE;
  end
  // snapshot operands and run both restoring dividers one quotient bit per cycle
  always_ff @(posedge CLK) begin
    if (Reset) begin
      iter  <= '0;
      s_cnt <= '0;
      s_mnx <= '0;
      s_mny <= '0;
      s_mxx <= '0;
      s_mxy <= '0;
      qx    <= '0;
      qy    <= '0;
      rx    <= '0;
      ry    <= '0;
    end else if (snap) begin
      iter  <= '0;
      s_cnt <= cnt;
      s_mnx <= min_x;
      s_mny <= min_y;
      s_mxx <= max_x;
      s_mxy <= max_y;
      qx    <= sum_x;
      qy    <= sum_y;
      rx    <= '0;
      ry    <= '0;
    end else if (step) begin
      iter <= iter + 5'd1;
      qx   <= {qx[28:0], gx};
      qy   <= {qy[28:0], gy};
      rx   <= gx ? 20'(tx - {1'b0, s_cnt}) : tx[19:0];
      ry   <= gy ? 20'(ty - {1'b0, s_cnt}) : ty[19:0];
    end
  end
  // publish results; a failed detection keeps the previous position and box
  always_ff @(posedge CLK) begin
    if (Reset) begin
      posX    <= '0;
      posY    <= '0;
      box_x0  <= '0;
      box_x1  <= '0;
      box_y0  <= '0;
      box_y1  <= '0;
      count   <= '0;
      found   <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= fin;
      if (eof2 && state != S_IDLE) overrun <= 1'b1;
      if (fin) begin
        count <= s_cnt;
        found <= ok;
        if (ok) begin
          posX   <= qx[9:0];
          posY   <= qy[9:0];
          box_x0 <= s_mnx;
          box_x1 <= s_mxx;
          box_y0 <= s_mny;
          box_y1 <= s_mxy;
        end
      end
    end
  end
endmodule
